// File: rtl/packet_cmd.sv
// rtl/packet_cmd.sv - packet RAM command decoder issuing configuration-register writes
module packet_cmd #(
    parameter logic [7:0] MAGIC0  = 8'h47,
    parameter logic [7:0] MAGIC1  = 8'h46,
    parameter int         MAX_REC = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eth_rx_ready,
    output logic        eth_rx_read,
    output logic [5:0]  eth_rx_raddr,
    input  logic [7:0]  eth_rx_rdata,
    input  logic        cfg_busy,
    output logic        cfg_we,
    output logic [7:0]  cfg_addr,
    output logic [15:0] cfg_wdata,
    output logic [7:0]  pkt_ok_count,
    output logic [7:0]  pkt_bad_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_ISSUE,
        S_RELEASE
    } state_t;

    localparam logic [7:0] MAX_REC_B = 8'(MAX_REC);

    state_t      state_q, state_d;
    logic [5:0]  raddr_q, raddr_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  rec_q, rec_d;
    logic [1:0]  fld_q, fld_d;
    logic        bad_q, bad_d;
    logic [7:0]  cfg_addr_q, cfg_addr_d;
    logic [15:0] cfg_wdata_q, cfg_wdata_d;
    logic [7:0]  ok_cnt_q, ok_cnt_d;
    logic [7:0]  bad_cnt_q, bad_cnt_d;

    assign eth_rx_raddr  = raddr_q;
    assign cfg_addr      = cfg_addr_q;
    assign cfg_wdata     = cfg_wdata_q;
    assign pkt_ok_count  = ok_cnt_q;
    assign pkt_bad_count = bad_cnt_q;

    // Next-state, byte decode and strobe generation; strobes are decoded from the state
    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        n_d         = n_q;
        rec_d       = rec_q;
        fld_d       = fld_q;
        bad_d       = bad_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        ok_cnt_d    = ok_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        cfg_we      = 1'b0;
        eth_rx_read = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (eth_rx_ready) begin
                    raddr_d = 6'd0;
                    bad_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                case (raddr_q)
                    6'd0: begin
                        if (eth_rx_rdata != MAGIC0) begin
                            bad_d   = 1'b1;
                            state_d = S_RELEASE;
                        end else begin
                            raddr_d = raddr_q + 6'd1;
                            state_d = S_FETCH;
                        end
                    end
                    6'd1: begin
                        if (eth_rx_rdata != MAGIC1) begin
                            bad_d   = 1'b1;
                            state_d = S_RELEASE;
                        end else begin
                            raddr_d = raddr_q + 6'd1;
                            state_d = S_FETCH;
                        end
                    end
                    6'd2: begin
                        n_d   = eth_rx_rdata;
                        rec_d = 8'd0;
                        fld_d = 2'd0;
                        if (eth_rx_rdata > MAX_REC_B) begin
                            bad_d   = 1'b1;
                            state_d = S_RELEASE;
                        end else if (eth_rx_rdata == 8'd0) begin
                            state_d = S_RELEASE;
                        end else begin
                            raddr_d = raddr_q + 6'd1;
                            state_d = S_FETCH;
                        end
                    end
                    default: begin
                        // Record fields are latched straight into the write-bus registers
                        case (fld_q)
                            2'd0: begin
                                cfg_addr_d = eth_rx_rdata;
                                fld_d      = 2'd1;
                                raddr_d    = raddr_q + 6'd1;
                                state_d    = S_FETCH;
                            end
                            2'd1: begin
                                cfg_wdata_d[15:8] = eth_rx_rdata;
                                fld_d             = 2'd2;
                                raddr_d           = raddr_q + 6'd1;
                                state_d           = S_FETCH;
                            end
                            default: begin
                                cfg_wdata_d[7:0] = eth_rx_rdata;
                                fld_d            = 2'd0;
                                state_d          = S_ISSUE;
                            end
                        endcase
                    end
                endcase
            end

            S_ISSUE: begin
                if (!cfg_busy) begin
                    cfg_we = 1'b1;
                    if (rec_q == n_q - 8'd1) begin
                        state_d = S_RELEASE;
                    end else begin
                        rec_d   = rec_q + 8'd1;
                        raddr_d = raddr_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_RELEASE: begin
                eth_rx_read = 1'b1;
                if (bad_q) begin
                    bad_cnt_d = bad_cnt_q + 8'd1;
                end else begin
                    ok_cnt_d = ok_cnt_q + 8'd1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            raddr_q     <= 6'd0;
            n_q         <= 8'd0;
            rec_q       <= 8'd0;
            fld_q       <= 2'd0;
            bad_q       <= 1'b0;
            cfg_addr_q  <= 8'd0;
            cfg_wdata_q <= 16'd0;
            ok_cnt_q    <= 8'd0;
            bad_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            n_q         <= n_d;
            rec_q       <= rec_d;
            fld_q       <= fld_d;
            bad_q       <= bad_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            ok_cnt_q    <= ok_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

endmodule

// File: tb/tb_packet_cmd.sv
// tb/tb_packet_cmd.sv - randomized self-checking bench for packet_cmd
module tb_packet_cmd;

    localparam logic [7:0] M0 = 8'h47;
    localparam logic [7:0] M1 = 8'h46;
    localparam int MAXR = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eth_rx_ready = 1'b0;
    logic        eth_rx_read;
    logic [5:0]  eth_rx_raddr;
    logic [7:0]  eth_rx_rdata;
    logic        cfg_busy = 1'b0;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [7:0]  pkt_ok_count;
    logic [7:0]  pkt_bad_count;

    logic [7:0]  mem [64];
    assign eth_rx_rdata = mem[eth_rx_raddr];

    packet_cmd #(.MAGIC0(M0), .MAGIC1(M1), .MAX_REC(MAXR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .eth_rx_ready  (eth_rx_ready),
        .eth_rx_read   (eth_rx_read),
        .eth_rx_raddr  (eth_rx_raddr),
        .eth_rx_rdata  (eth_rx_rdata),
        .cfg_busy      (cfg_busy),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .pkt_ok_count  (pkt_ok_count),
        .pkt_bad_count (pkt_bad_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_ok = 0;
    int exp_bad = 0;

    bit          busy_pat [512];
    bit          exp_we   [512];
    bit          exp_hold [512];
    logic [7:0]  exp_addr [512];
    logic [15:0] exp_data [512];
    int          exp_ra   [512];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " read"},  32'(eth_rx_read),   0);
        chk({tag, " raddr"}, 32'(eth_rx_raddr),  0);
        chk({tag, " we"},    32'(cfg_we),        0);
        chk({tag, " addr"},  32'(cfg_addr),      0);
        chk({tag, " wdata"}, 32'(cfg_wdata),     0);
        chk({tag, " ok"},    32'(pkt_ok_count),  0);
        chk({tag, " bad"},   32'(pkt_bad_count), 0);
    endtask

    task automatic clear_busy();
        for (int i = 0; i < 512; i++) busy_pat[i] = 1'b0;
    endtask

    task automatic rand_busy(input int pct);
        for (int i = 0; i < 512; i++) busy_pat[i] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic fill_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] nb);
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[0] = b0;
        mem[1] = b1;
        mem[2] = nb;
    endtask

    // Called from a point just after a rising edge; pulses reset and leaves it released mid-cycle
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        chk_all_zero(tag);
        exp_ok  = 0;
        exp_bad = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Presents mem[] as a ready packet (cycle 0 = now) and checks every cycle against the spec model
    task automatic run_pkt(input string tag, input int abort_at);
        int exp_read;
        int stall;
        int t;
        int n;
        bit good;
        bit rd;
        for (int i = 0; i < 512; i++) begin
            exp_we[i]   = 1'b0;
            exp_hold[i] = 1'b0;
            exp_addr[i] = 8'd0;
            exp_data[i] = 16'd0;
            exp_ra[i]   = 0;
        end
        n    = int'(mem[2]);
        good = 1'b0;
        if (mem[0] != M0) exp_read = 3;
        else if (mem[1] != M1) exp_read = 5;
        else if (n > MAXR) exp_read = 7;
        else begin
            good  = 1'b1;
            stall = 0;
            for (int i = 0; i < n; i++) begin
                t = 13 + 7 * i + stall;
                while (busy_pat[t] && t < 500) begin
                    exp_hold[t] = 1'b1;
                    exp_addr[t] = mem[3 + 3 * i];
                    exp_data[t] = {mem[4 + 3 * i], mem[5 + 3 * i]};
                    t++;
                    stall++;
                end
                exp_we[t]   = 1'b1;
                exp_addr[t] = mem[3 + 3 * i];
                exp_data[t] = {mem[4 + 3 * i], mem[5 + 3 * i]};
                exp_ra[t]   = 5 + 3 * i;
            end
            exp_read = 7 + 7 * n + stall;
        end
        if (abort_at < 0) begin
            if (good) exp_ok = (exp_ok + 1) % 256;
            else exp_bad = (exp_bad + 1) % 256;
        end

        eth_rx_ready = 1'b1;
        for (int c = 0; c <= exp_read + 1; c++) begin
            if (c == abort_at) begin
                cfg_busy = 1'b0;
                reset_pulse($sformatf("%s rst c%0d", tag, c));
                return;
            end
            cfg_busy = busy_pat[c];
            @(negedge clk);
            chk($sformatf("%s we c%0d", tag, c), 32'(cfg_we), 32'(exp_we[c]));
            chk($sformatf("%s read c%0d", tag, c), 32'(eth_rx_read), 32'(c == exp_read));
            if (exp_we[c] || exp_hold[c]) begin
                chk($sformatf("%s addr c%0d", tag, c), 32'(cfg_addr), 32'(exp_addr[c]));
                chk($sformatf("%s wdata c%0d", tag, c), 32'(cfg_wdata), 32'(exp_data[c]));
            end
            if (exp_we[c])
                chk($sformatf("%s raddr c%0d", tag, c), 32'(eth_rx_raddr), 32'(exp_ra[c]));
            if (c == exp_read + 1) begin
                chk($sformatf("%s ok_cnt", tag), 32'(pkt_ok_count), 32'(exp_ok));
                chk($sformatf("%s bad_cnt", tag), 32'(pkt_bad_count), 32'(exp_bad));
            end
            rd = eth_rx_read;
            @(posedge clk);
            #1;
            if (rd) eth_rx_ready = 1'b0;
        end
        eth_rx_ready = 1'b0;
        cfg_busy     = 1'b0;
    endtask

    task automatic load_two_rec();
        fill_pkt(M0, M1, 8'd2);
        mem[3] = 8'h10; mem[4] = 8'h12; mem[5] = 8'h34;
        mem[6] = 8'h2A; mem[7] = 8'hBE; mem[8] = 8'hEF;
    endtask

    initial begin
        int kind;
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 8'd0;
        clear_busy();

        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        load_two_rec();
        run_pkt("two_rec", -1);

        load_two_rec();
        clear_busy();
        for (int c = 13; c <= 17; c++) busy_pat[c] = 1'b1;
        run_pkt("two_rec_busy", -1);
        clear_busy();

        fill_pkt(8'h00, M1, 8'd2);
        run_pkt("bad_b0", -1);
        fill_pkt(M0, 8'h00, 8'd2);
        run_pkt("bad_b1", -1);
        fill_pkt(M0, M1, 8'd21);
        run_pkt("bad_n21", -1);
        fill_pkt(M0, M1, 8'd0);
        run_pkt("n0", -1);
        fill_pkt(M0, M1, 8'd20);
        run_pkt("n20", -1);

        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 7));
            n    = int'($urandom_range(0, 8));
            case (kind)
                0: fill_pkt(M0 ^ 8'($urandom_range(1, 255)), M1, 8'(n));
                1: fill_pkt(M0, M1 ^ 8'($urandom_range(1, 255)), 8'(n));
                2: fill_pkt(M0, M1, 8'($urandom_range(21, 255)));
                default: fill_pkt(M0, M1, 8'(n));
            endcase
            rand_busy(25);
            run_pkt($sformatf("rnd%0d", k), -1);
        end
        clear_busy();

        load_two_rec();
        run_pkt("abort", 16);
        chk("post_rst ok", 32'(pkt_ok_count), 0);
        chk("post_rst bad", 32'(pkt_bad_count), 0);
        run_pkt("redo", -1);

        reset_pulse("pre_wrap");
        for (int k = 0; k < 256; k++) begin
            fill_pkt(M0, M1, 8'($urandom_range(0, 3)));
            if (k % 4 == 0) rand_busy(30);
            else clear_busy();
            run_pkt($sformatf("wrap%0d", k), -1);
        end
        chk("wrap ok_cnt", 32'(pkt_ok_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/packet_cmd.md
# packet_cmd

Command decoder directly downstream of the Ethernet receiver. It waits for the receiver's 64-byte packet RAM to report a packet, then reads it back byte by byte. It validates a two-byte magic and a record count, issues one 16-bit configuration-register write per record on a simple write bus, and then releases the RAM back to the receiver with a one-cycle `eth_rx_read` pulse. Saturating-free (wrapping) counters report good and rejected packets.

## Interface
- `MAGIC0`, default 8'h47: required value of payload byte 0.
- `MAGIC1`, default 8'h46: required value of payload byte 1.
- `MAX_REC`, default 20: largest accepted record count (3 + 3*20 = 63 bytes, which fits in the RAM).
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `eth_rx_ready`  in  1  receiver has a complete packet in RAM; held high until `eth_rx_read`.
- `eth_rx_read`  out  1  one-cycle pulse that releases the RAM to the receiver.
- `eth_rx_raddr`  out  6  RAM read address (registered).
- `eth_rx_rdata`  in  8  RAM read data; contents of the address registered at the previous edge (1-cycle latency).
- `cfg_busy`  in  1  downstream register/SPI engine cannot accept a write.
- `cfg_we`  out  1  one-cycle write strobe.
- `cfg_addr`  out  8  register address; valid while `cfg_we`=1.
- `cfg_wdata`  out  16  register data; valid while `cfg_we`=1.
- `pkt_ok_count`  out  8  count of accepted packets, wraps 255->0.
- `pkt_bad_count`  out  8  count of rejected packets, wraps 255->0.

## Operation
- Packet format: byte0 = `MAGIC0`, byte1 = `MAGIC1`, byte2 = record count N, then N records of 3 bytes each: addr, data[15:8], data[7:0]. Bytes beyond 2+3N are ignored.
- States:
  - IDLE: if `eth_rx_ready`=1, set `eth_rx_raddr`<=0 and go to FETCH.
  - FETCH: a one-cycle wait for the RAM latency; go to CAPTURE.
  - CAPTURE: latch `eth_rx_rdata` according to the byte index, then do one of the following:
    - Advance `eth_rx_raddr` and return to FETCH.
    - After the last byte of a record, go to ISSUE.
    - On a decode failure, go to RELEASE.
  - ISSUE: hold while `cfg_busy`=1. When `cfg_busy`=0, drive `cfg_we`=1 for exactly one cycle with the latched addr/data. Then either advance `eth_rx_raddr` and go to FETCH, or, if this was record N-1, go to RELEASE.
  - RELEASE: drive `eth_rx_read`=1 for one cycle, update the appropriate counter, and return to IDLE.
- Rejection:
  - byte0 != `MAGIC0`, byte1 != `MAGIC1`, or N > `MAX_REC` causes an immediate RELEASE with `pkt_bad_count`+1.
  - A rejected packet produces no `cfg_we`.
- N=0 with a valid magic is accepted: no writes, `pkt_ok_count`+1.
- Data byte order is big-endian: `cfg_wdata` = {byte at addr+1, byte at addr+2}.
- `eth_rx_ready` is sampled only in IDLE. It is a don't-care in all other states, including if it drops unexpectedly.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - `eth_rx_read`=0, `eth_rx_raddr`=0, `cfg_we`=0, `cfg_addr`=0, `cfg_wdata`=0, `pkt_ok_count`=0, `pkt_bad_count`=0.
  - A packet interrupted mid-decode is not released. After reset deasserts, it is re-decoded from byte 0, and any writes it had already issued are re-issued.

## Timing
- Cycle 0 is the IDLE cycle in which `eth_rx_ready`=1 is seen.
- Byte k of the header (k=0..2) is captured in cycle 2+2k.
- With `cfg_busy`=0:
  - Record i's bytes are captured in cycles 8+7i, 10+7i and 12+7i.
  - `cfg_we` for record i is asserted in cycle 13+7i.
  - `eth_rx_read` is asserted in cycle 7+7N.
- Each cycle that `cfg_busy`=1 while in ISSUE delays every later event by one cycle. `cfg_addr`/`cfg_wdata` hold stable throughout the stall.
- Rejection timing:
  - Bad byte0: `eth_rx_read` in cycle 3.
  - Bad byte1: `eth_rx_read` in cycle 5.
  - Bad count: `eth_rx_read` in cycle 7.
- The counter increments become visible in the cycle after the `eth_rx_read` pulse.
- The earliest re-trigger is the cycle after RELEASE. The receiver drops `eth_rx_ready` on the edge that samples `eth_rx_read`, so one packet produces no double decode.

## Test plan
- Valid packet 47 46 02 | 10 12 34 | 2A BE EF, busy=0:
  - `cfg_we` at cycle 13 with (10, 1234) and at cycle 20 with (2A, BEEF).
  - `eth_rx_read` at cycle 21.
  - `pkt_ok_count`=1.
- Same packet with `cfg_busy`=1 for cycles 13-17:
  - The first `cfg_we` occurs at cycle 18.
  - `cfg_addr`/`cfg_wdata` are stable during the stall.
  - `eth_rx_read` at cycle 26.
- Magic errors and bad count:
  - byte0=00: `eth_rx_read` at cycle 3.
  - byte1=00: `eth_rx_read` at cycle 5.
  - N=21: `eth_rx_read` at cycle 7.
  - In all three cases there is no `cfg_we` and `pkt_bad_count` increments.
- Boundary counts:
  - N=0: `eth_rx_read` at cycle 7, `pkt_ok_count`+1.
  - N=20: 20 writes, the last reading RAM addr 62; `eth_rx_read` at cycle 147.
- `rst_n` pulsed low at cycle 16 of the two-record packet:
  - All outputs go to 0 immediately.
  - After release, decode restarts and (10, 1234) is written again.
  - Counters are 0 before this packet's increment.
- 256 accepted packets back to back: `pkt_ok_count` wraps to 0, and `eth_rx_read` pulses exactly once per packet.
